// File: rtl/call_request_queue.sv
// -----------------------------------------------------------------------------
// call_request_queue
//
// Front-end capture stage for the elevator controller. The ten raw call
// inputs and three hall direction switches are synchronised and (optionally)
// debounced. Each press is latched as a pending request, and pending requests
// are offered to the controller one at a time over a valid/ready handshake.
// A request stays pending until the controller reports its floor as served.
//
// Build option:
//   CALL_QUEUE_DEBOUNCE_EN  defined   -> per-bit debounce counters, a level
//                                        changes after DEBOUNCE_CYCLES stable
//                                        samples
//                           undefined -> debounced level is the synchroniser
//                                        output, DEBOUNCE_CYCLES is unused
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples before a debounced level flips (1..15)
//
// Ports:
//   clk_50hz   in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   call_p     in   [4:0] raw hall buttons, bit i = floor i
//   call_d     in   [4:0] raw cabin switches, bit i = floor i
//   dir_sw     in   [2:0] raw hall direction switches, floors 1..3, 1 = up
//   cur_floor  in   [2:0] controller's current floor
//   req_ready  in   controller accepts the offered request
//   clr_valid  in   one-cycle pulse, floor clr_floor has been served
//   clr_floor  in   [2:0] served floor
//   req_valid  out  request offered
//   req_floor  out  [2:0] offered floor
//   req_dir    out  requested direction, 1 = up
//   req_src    out  0 = hall call, 1 = cabin call
//   pending_p  out  [4:0] pending hall calls (outside LEDs)
//   pending_d  out  [4:0] pending cabin calls (inside LEDs)
// -----------------------------------------------------------------------------
module call_request_queue #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk_50hz,
  input  logic       rst,
  input  logic [4:0] call_p,
  input  logic [4:0] call_d,
  input  logic [2:0] dir_sw,
  input  logic [2:0] cur_floor,
  input  logic       req_ready,
  input  logic       clr_valid,
  input  logic [2:0] clr_floor,
  output logic       req_valid,
  output logic [2:0] req_floor,
  output logic       req_dir,
  output logic       req_src,
  output logic [4:0] pending_p,
  output logic [4:0] pending_d
);

  typedef enum logic {IDLE, OFFER} stateT;

  // A debounce count outside 1..15 cannot be represented by the 4-bit counters.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : gBadDebounce
    $error("call_request_queue: DEBOUNCE_CYCLES must be in 1..15");
  end

  // Raw input bundle: [4:0] cabin, [9:5] hall, [12:10] direction switches.
  logic [12:0] rawIn;
  logic [12:0] syncA;
  logic [12:0] syncB;
  logic [12:0] debLevel;
  logic [9:0]  debPrev;
  logic [9:0]  rise;
  logic [4:0]  riseD;
  logic [4:0]  riseP;
  logic [4:0]  hallDirIn;
  logic [4:0]  hallDir;
  logic [4:0]  hallLatch;
  logic [4:0]  clrMask;
  logic [4:0]  issuedD;
  logic [4:0]  issuedP;
  logic [9:0]  cand;
  logic [9:0]  acceptVec;
  logic        accept;
  logic        offerCleared;
  logic        found;
  logic [3:0]  winIdx;
  logic [2:0]  winFloor;
  logic        winSrc;
  logic        winDir;
  logic [3:0]  rrPtr;
  logic [3:0]  offerIdx;
  stateT       state;

  assign rawIn = {dir_sw, call_p, call_d};

  // Two-flop synchroniser on every raw input; the switches are asynchronous
  // to the system clock.
  always_ff @(posedge clk_50hz or negedge rst) begin
    if (!rst) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= rawIn;
      syncB <= syncA;
    end
  end

`ifdef CALL_QUEUE_DEBOUNCE_EN
  localparam logic [3:0] DebLast = 4'(DEBOUNCE_CYCLES - 1);

  logic [3:0] debCount [13];

  // Per-bit debounce: count consecutive samples that disagree with the
  // debounced level; the level follows once the count reaches
  // DEBOUNCE_CYCLES, and any agreeing sample restarts the count.
  always_ff @(posedge clk_50hz or negedge rst) begin
    if (!rst) begin
      debLevel <= '0;
      for (int i = 0; i < 13; i++) begin
        debCount[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (syncB[i] != debLevel[i]) begin
          if (debCount[i] == DebLast) begin
            debLevel[i] <= syncB[i];
            debCount[i] <= '0;
          end else begin
            debCount[i] <= debCount[i] + 4'd1;
          end
        end else begin
          debCount[i] <= '0;
        end
      end
    end
  end
`else
  assign debLevel = syncB;
`endif

  // Previous debounced call levels, for rising-edge detection of presses.
  always_ff @(posedge clk_50hz or negedge rst) begin
    if (!rst) begin
      debPrev <= '0;
    end else begin
      debPrev <= debLevel[9:0];
    end
  end

  assign rise  = debLevel[9:0] & ~debPrev;
  assign riseD = rise[4:0];
  assign riseP = rise[9:5];

  // Floor 0 can only go up and floor 4 only down; floors 1..3 ask the switch.
  assign hallDirIn = {1'b0, debLevel[12:10], 1'b1};

  // A served floor clears both call sources; out-of-range floors do nothing.
  assign clrMask = (clr_valid && (clr_floor <= 3'd4)) ? (5'b00001 << clr_floor) : 5'b00000;

  // Only a fresh press that is not being cleared records a hall direction,
  // so a repeated press cannot change the direction of a pending call.
  assign hallLatch = riseP & ~pending_p & ~clrMask;

  assign offerCleared = (state == OFFER) && clr_valid && (clr_floor == req_floor);
  assign accept       = (state == OFFER) && req_ready && !offerCleared;
  assign acceptVec    = accept ? (10'b1 << offerIdx) : 10'b0;

  // Pending and issued bookkeeping. A clear on the same edge as a set wins,
  // so the press is lost. Issued bits keep an accepted request from being
  // offered again until its floor is served.
  always_ff @(posedge clk_50hz or negedge rst) begin
    if (!rst) begin
      pending_p <= '0;
      pending_d <= '0;
      issuedD   <= '0;
      issuedP   <= '0;
      hallDir   <= '0;
    end else begin
      pending_d <= (pending_d | riseD) & ~clrMask;
      pending_p <= (pending_p | riseP) & ~clrMask;
      issuedD   <= (issuedD | acceptVec[4:0]) & ~clrMask;
      issuedP   <= (issuedP | acceptVec[9:5]) & ~clrMask;
      hallDir   <= (hallDir & ~hallLatch) | (hallDirIn & hallLatch);
    end
  end

  // Candidates exclude anything being cleared this very edge so a served
  // floor is never offered.
  assign cand = {pending_p & ~issuedP, pending_d & ~issuedD} & ~{clrMask, clrMask};

  // Round-robin search over d0..d4, p0..p4 starting at rrPtr.
  always_comb begin
    logic [3:0] idx;
    found  = 1'b0;
    winIdx = 4'd0;
    idx    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      idx = 4'((int'(rrPtr) + i) % 10);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winIdx = idx;
      end
    end
  end

  // Cabin calls carry no direction of their own: it is derived from where
  // the car is at the moment the request is offered.
  always_comb begin
    winSrc   = (winIdx < 4'd5);
    winFloor = winSrc ? winIdx[2:0] : 3'(winIdx - 4'd5);
    winDir   = winSrc ? (winFloor > cur_floor) : hallDir[winFloor];
  end

  // Offer FSM. In OFFER every req_* output holds still until the controller
  // accepts, or until the offered floor is served, which is the only way an
  // offer is withdrawn.
  always_ff @(posedge clk_50hz or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_floor <= '0;
      req_dir   <= 1'b0;
      req_src   <= 1'b0;
      offerIdx  <= '0;
      rrPtr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= OFFER;
            req_valid <= 1'b1;
            req_floor <= winFloor;
            req_dir   <= winDir;
            req_src   <= winSrc;
            offerIdx  <= winIdx;
          end
        end
        OFFER: begin
          if (offerCleared) begin
            state     <= IDLE;
            req_valid <= 1'b0;
          end else if (req_ready) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            rrPtr     <= (offerIdx == 4'd9) ? 4'd0 : offerIdx + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
